lfsr_rng: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random word generator with a valid/ready output handshake, runtime seeding and an overrun flag. It generalises the fixed 13-bit generator to any width and tap set, and delivers a fresh word only after WIDTH shifts so successive outputs do not overlap. Game and animation logic consume its words wherever randomised positions, colours or delays are needed.

---
 rtl/lfsr_rng.sv | 78 +++++++
 tb/tb_lfsr_rng.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Parametrised Fibonacci LFSR word generator with valid/ready output, runtime seeding and sticky overrun.
// Define LFSR_RNG_RANGE_EN to add the `limit` port that rejects completed words >= limit.
module lfsr_rng #(
   parameter int               WIDTH = 13,
   parameter logic [WIDTH-1:0] TAPS  = 13'h100D,
   parameter logic [WIDTH-1:0] SEED  = '1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] rnd,
   output logic             rnd_valid,
   input  logic             rnd_ready,
`ifdef LFSR_RNG_RANGE_EN
   input  logic [WIDTH-1:0] limit,
`endif
   output logic             overrun
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_next;
   logic [CW-1:0]    count;
   logic             fb;
   logic             wrap;
   logic             complete;
   logic             eligible;
   logic             transfer;

   // A word completes on the shift that wraps the counter; the word is the post-shift state.
   always_comb begin
      fb        = ^(lfsr & TAPS);
      lfsr_next = {lfsr[WIDTH-2:0], fb};
      wrap      = (count == LAST);
      complete  = enable && !seed_load && wrap;
      transfer  = rnd_valid && rnd_ready;
`ifdef LFSR_RNG_RANGE_EN
      eligible  = complete && (lfsr_next < limit);
`else
      eligible  = complete;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr      <= SEED;
         count     <= '0;
         rnd       <= '0;
         rnd_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // A zero seed would lock the register up, so fall back to SEED.
         if (seed_load) begin
            lfsr  <= (seed_in == '0) ? SEED : seed_in;
            count <= '0;
         end else if (enable) begin
            lfsr  <= lfsr_next;
            count <= wrap ? '0 : count + 1'b1;
         end

         if (eligible) begin
            if (!rnd_valid || rnd_ready) begin
               rnd       <= lfsr_next;
               rnd_valid <= 1'b1;
            end else begin
               overrun   <= 1'b1;
            end
         end else if (transfer) begin
            rnd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng at WIDTH=4, TAPS=4'b1001, SEED=4'b0001.
// Directed scenarios use known sequence values; a randomized run is checked against a behavioural model.
module tb_lfsr_rng;

   localparam int         W     = 4;
   localparam logic [3:0] TAPS  = 4'b1001;
   localparam logic [3:0] SEED  = 4'b0001;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       seed_load = 1'b0;
   logic [3:0] seed_in = 4'h0;
   logic [3:0] rnd;
   logic       rnd_valid;
   logic       rnd_ready = 1'b0;
   logic       overrun;
   logic [3:0] limit = 4'hF;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: plain integers stepped once per clock edge.
   int         m_state;
   int         m_shifts;
   logic [3:0] m_rnd;
   logic       m_valid;
   logic       m_overrun;

   always #5 clock = ~clock;

   lfsr_rng #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .rnd       (rnd),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
`ifdef LFSR_RNG_RANGE_EN
      .limit     (limit),
`endif
      .overrun   (overrun)
   );

   // Next state is (state * 2 mod 16) plus the parity of the tapped bits.
   function automatic int next_state(input int s);
      int p;
      p = $countones(s & int'(TAPS)) % 2;
      return ((s * 2) % 16) + p;
   endfunction

   function automatic bit word_ok(input int w);
`ifdef LFSR_RNG_RANGE_EN
      return w < int'(limit);
`else
      return 1'b1;
`endif
   endfunction

   // Drive one edge worth of inputs, advance the model, then sample 1 time unit after the edge.
   task automatic tick(input bit rst, input bit en, input bit sl, input logic [3:0] si, input bit rdy);
      bit take;
      bit done;
      reset     = rst;
      enable    = en;
      seed_load = sl;
      seed_in   = si;
      rnd_ready = rdy;
      if (rst) begin
         m_state = int'(SEED); m_shifts = 0;
         m_rnd = 4'h0; m_valid = 1'b0; m_overrun = 1'b0;
      end else begin
         take = m_valid && rdy;
         done = 1'b0;
         if (sl) begin
            m_state  = (si == 4'h0) ? int'(SEED) : int'(si);
            m_shifts = 0;
         end else if (en) begin
            m_state  = next_state(m_state);
            m_shifts = m_shifts + 1;
            if (m_shifts == W) begin
               m_shifts = 0;
               done = 1'b1;
            end
         end
         if (done && word_ok(m_state)) begin
            if (!m_valid || take) begin
               m_rnd = 4'(m_state); m_valid = 1'b1;
            end else begin
               m_overrun = 1'b1;
            end
         end else if (take) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 4'h0, 0);
      tick(1, 1, 1, 4'h5, 1);
      total++; if (rnd !== 4'h0) begin bad++; $display("[TB] FAIL reset_rnd: got %h expected 0", rnd); end
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", rnd_valid); end
      total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_stream();
      logic [3:0] exp_words [3] = '{4'hE, 4'hB, 4'h2};
      tick(1, 0, 0, 4'h0, 0);
      for (int k = 0; k < 12; k++) begin
         tick(0, 1, 0, 4'h0, 1);
         total++;
         if (rnd_valid !== (k % 4 == 3)) begin
            bad++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", k, rnd_valid, (k % 4 == 3));
         end
         if (k % 4 == 3) begin
            total++;
            if (rnd !== exp_words[k / 4]) begin
               bad++; $display("[TB] FAIL stream_word[%0d]: got %h expected %h", k / 4, rnd, exp_words[k / 4]);
            end
         end
      end
      // 60 shifts is four full periods, so the word there is the reset state again.
      for (int k = 12; k < 60; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'h1) begin bad++; $display("[TB] FAIL period: got valid=%b rnd=%h expected valid=1 rnd=1", rnd_valid, rnd); end
      total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL stream_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_overrun();
      tick(1, 0, 0, 4'h0, 0);
      for (int k = 0; k < 4; k++) tick(0, 1, 0, 4'h0, 0);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'hE || overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_first: got valid=%b rnd=%h ovr=%b expected 1 e 0", rnd_valid, rnd, overrun); end
      for (int k = 4; k < 8; k++) tick(0, 1, 0, 4'h0, 0);
      total++; if (rnd !== 4'hE || rnd_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_hold: got valid=%b rnd=%h expected 1 e", rnd_valid, rnd); end
      total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_set: got %b expected 1", overrun); end
      tick(0, 0, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_drain: got %b expected 0", rnd_valid); end
      tick(0, 1, 0, 4'h0, 1);
      total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_seed();
      tick(1, 0, 0, 4'h0, 0);
      tick(0, 1, 0, 4'h0, 1);
      tick(0, 1, 0, 4'h0, 1);
      tick(0, 1, 1, 4'h0, 1);
      for (int k = 0; k < 3; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("[TB] FAIL seed_count_restart: got %b expected 0", rnd_valid); end
      tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'hE) begin bad++; $display("[TB] FAIL seed_zero: got valid=%b rnd=%h expected 1 e", rnd_valid, rnd); end
      tick(0, 1, 1, 4'hE, 1);
      for (int k = 0; k < 4; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'hB) begin bad++; $display("[TB] FAIL seed_e: got valid=%b rnd=%h expected 1 b", rnd_valid, rnd); end
   endtask

   task automatic test_back_to_back();
      tick(1, 0, 0, 4'h0, 0);
      for (int k = 0; k < 7; k++) tick(0, 1, 0, 4'h0, 0);
      tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'hB) begin bad++; $display("[TB] FAIL b2b_word: got valid=%b rnd=%h expected 1 b", rnd_valid, rnd); end
      total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_reset_mid_word();
      tick(1, 0, 0, 4'h0, 0);
      for (int k = 0; k < 6; k++) tick(0, 1, 0, 4'h0, 0);
      tick(1, 1, 0, 4'h0, 0);
      total++; if (rnd !== 4'h0 || rnd_valid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset: got rnd=%h valid=%b ovr=%b expected 0 0 0", rnd, rnd_valid, overrun); end
      for (int k = 0; k < 3; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_partial: got %b expected 0", rnd_valid); end
      tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'hE) begin bad++; $display("[TB] FAIL mid_next: got valid=%b rnd=%h expected 1 e", rnd_valid, rnd); end
   endtask

`ifdef LFSR_RNG_RANGE_EN
   task automatic test_range();
      limit = 4'hC;
      tick(1, 0, 0, 4'h0, 0);
      for (int k = 0; k < 4; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL range_reject: got valid=%b ovr=%b expected 0 0", rnd_valid, overrun); end
      for (int k = 4; k < 8; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'hB) begin bad++; $display("[TB] FAIL range_first: got valid=%b rnd=%h expected 1 b", rnd_valid, rnd); end
      for (int k = 8; k < 12; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b1 || rnd !== 4'h2) begin bad++; $display("[TB] FAIL range_second: got valid=%b rnd=%h expected 1 2", rnd_valid, rnd); end
      limit = 4'h0;
      for (int k = 0; k < 16; k++) tick(0, 1, 0, 4'h0, 1);
      total++; if (rnd_valid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL range_zero: got valid=%b ovr=%b expected 0 0", rnd_valid, overrun); end
      limit = 4'hF;
   endtask
`endif

   task automatic test_random();
      bit         r_rst, r_en, r_sl, r_rdy;
      logic [3:0] r_si;
      tick(1, 0, 0, 4'h0, 0);
      for (int k = 0; k < 600; k++) begin
         r_rst = ($urandom_range(0, 59) == 0);
         r_en  = ($urandom_range(0, 3) != 0);
         r_sl  = ($urandom_range(0, 19) == 0);
         r_rdy = ($urandom_range(0, 2) != 0);
         r_si  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
`ifdef LFSR_RNG_RANGE_EN
         if ($urandom_range(0, 29) == 0) limit = 4'($urandom);
`endif
         tick(r_rst, r_en, r_sl, r_si, r_rdy);
         total++;
         if (rnd !== m_rnd || rnd_valid !== m_valid || overrun !== m_overrun) begin
            bad++;
            $display("[TB] FAIL random[%0d]: got rnd=%h valid=%b ovr=%b expected rnd=%h valid=%b ovr=%b",
                     k, rnd, rnd_valid, overrun, m_rnd, m_valid, m_overrun);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_overrun();
      test_seed();
      test_back_to_back();
      test_reset_mid_word();
`ifdef LFSR_RNG_RANGE_EN
      test_range();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
